// File: rtl/xdma_arb_pkg.sv
// Shared widths, FSM state encoding and port-id type for the XDMA C2H packet arbiter.
package xdma_arb_pkg;

   localparam int TDATA_WIDTH_DEF = 512;
   localparam int TKEEP_WIDTH_DEF = 64;
   localparam int TUSER_WIDTH_DEF = 1;
   localparam int CNT_WIDTH_DEF   = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } arb_state_e;

   typedef logic port_id_t;

endpackage

// File: rtl/xdma_c2h_pkt_arbiter_if.sv
// AXI-Stream bundle used for both requester ports and the C2H master port of the arbiter.
interface xdma_c2h_pkt_arbiter_if
   import xdma_arb_pkg::*;
#(
   parameter int TDATA_WIDTH = TDATA_WIDTH_DEF,
   parameter int TKEEP_WIDTH = TKEEP_WIDTH_DEF,
   parameter int TUSER_WIDTH = TUSER_WIDTH_DEF
);
   logic                   tvalid;
   logic                   tready;
   logic                   tlast;
   logic [TDATA_WIDTH-1:0] tdata;
   logic [TKEEP_WIDTH-1:0] tkeep;
   logic [TUSER_WIDTH-1:0] tuser;

   modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
   modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);

endinterface

// File: rtl/xdma_arb_stat_cnt.sv
// Per-port statistics: beat counter (every handshake) and packet counter (tlast handshake), both wrapping.
module xdma_arb_stat_cnt
   import xdma_arb_pkg::*;
#(
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 beat_hs,
   input  logic                 beat_last,
   input  logic                 pkt_load,
   input  logic [CNT_WIDTH-1:0] pkt_load_val,
   output logic [CNT_WIDTH-1:0] pkt_cnt,
   output logic [CNT_WIDTH-1:0] beat_cnt
);

   logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      // NOTE: defaults first, so no path through the block leaves a signal unassigned and infers a latch.
      pkt_cnt_d  = pkt_cnt_q;
      beat_cnt_d = beat_cnt_q;
      if (beat_hs) begin
         beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
         if (beat_last) begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
         end
      end
      if (pkt_load) begin
         pkt_cnt_d = pkt_load_val;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pkt_cnt_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
         pkt_cnt_q  <= pkt_cnt_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign beat_cnt = beat_cnt_q;

endmodule

// File: rtl/xdma_c2h_pkt_arbiter.sv
// Packet-granular 2:1 AXIS arbiter for the XDMA C2H channel; round-robin unless
// XDMA_C2H_ARB_STRICT_PRIO_EN is defined (port 0 then always wins a tie).
module xdma_c2h_pkt_arbiter
   import xdma_arb_pkg::*;
#(
   parameter int TDATA_WIDTH = TDATA_WIDTH_DEF,
   parameter int TKEEP_WIDTH = TKEEP_WIDTH_DEF,
   parameter int TUSER_WIDTH = TUSER_WIDTH_DEF,
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   arb_enable,
   xdma_c2h_pkt_arbiter_if.slave  s0_axis,
   xdma_c2h_pkt_arbiter_if.slave  s1_axis,
   xdma_c2h_pkt_arbiter_if.master m_axis,
   input  logic [1:0]             tst_pkt_load,
   input  logic [CNT_WIDTH-1:0]   tst_pkt_val,
   output logic                   grant_id,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   pkt_cnt0,
   output logic [CNT_WIDTH-1:0]   pkt_cnt1,
   output logic [CNT_WIDTH-1:0]   beat_cnt0,
   output logic [CNT_WIDTH-1:0]   beat_cnt1
);

   arb_state_e state_q, state_d;
   port_id_t   last_grant_q, last_grant_d;
   port_id_t   pick;
   logic       any_req;
   logic       hs0, hs1;

   assign any_req = s0_axis.tvalid | s1_axis.tvalid;
   assign hs0     = (state_q == ST_GRANT0) & s0_axis.tvalid & m_axis.tready;
   assign hs1     = (state_q == ST_GRANT1) & s1_axis.tvalid & m_axis.tready;

   // Winner if the FSM grants this cycle; a lone requester always wins.
   always_comb begin
      pick = s1_axis.tvalid;
      if (s0_axis.tvalid && s1_axis.tvalid) begin
`ifdef XDMA_C2H_ARB_STRICT_PRIO_EN
         pick = 1'b0;
`else
         pick = ~last_grant_q;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      m_axis.tvalid  = 1'b0;
      m_axis.tlast   = 1'b0;
      m_axis.tdata   = {TDATA_WIDTH{1'b0}};
      m_axis.tkeep   = {TKEEP_WIDTH{1'b0}};
      m_axis.tuser   = {TUSER_WIDTH{1'b0}};
      s0_axis.tready = 1'b0;
      s1_axis.tready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_enable && any_req) begin
               state_d      = pick ? ST_GRANT1 : ST_GRANT0;
               last_grant_d = pick;
            end
         end
         ST_GRANT0: begin
            m_axis.tvalid  = s0_axis.tvalid;
            m_axis.tlast   = s0_axis.tlast;
            m_axis.tdata   = s0_axis.tdata;
            m_axis.tkeep   = s0_axis.tkeep;
            m_axis.tuser   = s0_axis.tuser;
            s0_axis.tready = m_axis.tready;
            if (hs0 && s0_axis.tlast) state_d = ST_IDLE;
         end
         ST_GRANT1: begin
            m_axis.tvalid  = s1_axis.tvalid;
            m_axis.tlast   = s1_axis.tlast;
            m_axis.tdata   = s1_axis.tdata;
            m_axis.tkeep   = s1_axis.tkeep;
            m_axis.tuser   = s1_axis.tuser;
            s1_axis.tready = m_axis.tready;
            if (hs1 && s1_axis.tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // last_grant resets to 1 so port 0 wins the first tie after reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign grant_id = (state_q == ST_GRANT1);

   xdma_arb_stat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt0 (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .beat_hs      (hs0),
      .beat_last    (s0_axis.tlast),
      .pkt_load     (tst_pkt_load[0]),
      .pkt_load_val (tst_pkt_val),
      .pkt_cnt      (pkt_cnt0),
      .beat_cnt     (beat_cnt0)
   );

   xdma_arb_stat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt1 (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .beat_hs      (hs1),
      .beat_last    (s1_axis.tlast),
      .pkt_load     (tst_pkt_load[1]),
      .pkt_load_val (tst_pkt_val),
      .pkt_cnt      (pkt_cnt1),
      .beat_cnt     (beat_cnt1)
   );

endmodule

// File: tb/tb_xdma_c2h_pkt_arbiter.sv
// Scoreboard bench for xdma_c2h_pkt_arbiter: per-port beat queues, expected grant order, counter model.
module tb_xdma_c2h_pkt_arbiter;
   import xdma_arb_pkg::*;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         user;
      logic         last;
   } beat_t;

   logic        CLK;
   logic        RST_N;
   logic        arb_enable;
   logic [1:0]  tst_pkt_load;
   logic [31:0] tst_pkt_val;
   logic        grant_id;
   logic        busy;
   logic [31:0] pkt_cnt0, pkt_cnt1, beat_cnt0, beat_cnt1;

   xdma_c2h_pkt_arbiter_if s0_if ();
   xdma_c2h_pkt_arbiter_if s1_if ();
   xdma_c2h_pkt_arbiter_if m_if ();

   xdma_c2h_pkt_arbiter dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .arb_enable   (arb_enable),
      .s0_axis      (s0_if),
      .s1_axis      (s1_if),
      .m_axis       (m_if),
      .tst_pkt_load (tst_pkt_load),
      .tst_pkt_val  (tst_pkt_val),
      .grant_id     (grant_id),
      .busy         (busy),
      .pkt_cnt0     (pkt_cnt0),
      .pkt_cnt1     (pkt_cnt1),
      .beat_cnt0    (beat_cnt0),
      .beat_cnt1    (beat_cnt1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          pkt_seq  = 0;
   beat_t       tx_q0[$], tx_q1[$], exp_q0[$], exp_q1[$];
   logic        exp_grant[$];
   logic [31:0] exp_pkt [2];
   logic [31:0] exp_beat[2];
   logic [1:0]  hs_seen;
   logic        in_pkt, cur_port, bubble_pend, stall_pend;
   logic [511:0] stall_data;

   task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic send_pkt(input int p, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
         b.data[15:0] = {4'(p), 4'(pkt_seq), 8'(i)};
         b.keep = (i == len - 1) ? {$urandom, $urandom} : '1;
         b.user = 1'($urandom);
         b.last = (i == len - 1);
         if (p == 0) begin tx_q0.push_back(b); exp_q0.push_back(b); end
         else        begin tx_q1.push_back(b); exp_q1.push_back(b); end
      end
      exp_pkt[p]  = exp_pkt[p] + 32'd1;
      exp_beat[p] = exp_beat[p] + 32'(len);
      pkt_seq++;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((tx_q0.size() > 0 || tx_q1.size() > 0 || exp_q0.size() > 0 || exp_q1.size() > 0
              || busy) && n < 300) begin
         step();
         n++;
      end
      check("drain_done", n < 300, 1'b1);
      step();
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_pkt_cnt0"},  pkt_cnt0,  exp_pkt[0]);
      check({tag, "_pkt_cnt1"},  pkt_cnt1,  exp_pkt[1]);
      check({tag, "_beat_cnt0"}, beat_cnt0, exp_beat[0]);
      check({tag, "_beat_cnt1"}, beat_cnt1, exp_beat[1]);
   endtask

   // Source drivers: retire a beat one edge after its handshake, then present the queue head.
   initial begin
      beat_t b;
      s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0; s0_if.tdata = '0; s0_if.tkeep = '0; s0_if.tuser = '0;
      s1_if.tvalid = 1'b0; s1_if.tlast = 1'b0; s1_if.tdata = '0; s1_if.tkeep = '0; s1_if.tuser = '0;
      forever begin
         @(posedge CLK);
         #1;
         if (hs_seen[0] && tx_q0.size() > 0) void'(tx_q0.pop_front());
         if (hs_seen[1] && tx_q1.size() > 0) void'(tx_q1.pop_front());
         b = (tx_q0.size() > 0) ? tx_q0[0] : '0;
         s0_if.tvalid = (tx_q0.size() > 0);
         s0_if.tdata = b.data; s0_if.tkeep = b.keep; s0_if.tuser = b.user; s0_if.tlast = b.last;
         b = (tx_q1.size() > 0) ? tx_q1[0] : '0;
         s1_if.tvalid = (tx_q1.size() > 0);
         s1_if.tdata = b.data; s1_if.tkeep = b.keep; s1_if.tuser = b.user; s1_if.tlast = b.last;
      end
   end

   // Output monitor: grant order, atomicity, payload, bubble and stall stability.
   always @(negedge CLK) begin
      beat_t e;
      logic  port;
      if (!RST_N) begin
         hs_seen = 2'b00; in_pkt = 1'b0; bubble_pend = 1'b0; stall_pend = 1'b0;
      end else begin
         hs_seen = {s1_if.tvalid & s1_if.tready, s0_if.tvalid & s0_if.tready};
         if (bubble_pend) begin
            check("bubble_busy", busy, 1'b0);
            bubble_pend = 1'b0;
         end
         if (stall_pend) begin
            check("stall_hold", m_if.tdata, stall_data);
            stall_pend = 1'b0;
         end
         if (m_if.tvalid && !m_if.tready) begin
            stall_pend = 1'b1;
            stall_data = m_if.tdata;
         end
         if (m_if.tvalid && m_if.tready) begin
            port = grant_id;
            if (!in_pkt) begin
               if (exp_grant.size() == 0) check("grant_unexpected", 1'b1, 1'b0);
               else check("grant_order", port, exp_grant.pop_front());
               cur_port = port;
               in_pkt   = 1'b1;
            end else begin
               check("no_interleave", port, cur_port);
            end
            if (port == 1'b0 && exp_q0.size() > 0)      e = exp_q0.pop_front();
            else if (port == 1'b1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            else e = '0;
            check("beat_data", m_if.tdata, e.data);
            check("beat_side", {m_if.tkeep, m_if.tuser, m_if.tlast}, {e.keep, e.user, e.last});
            if (m_if.tlast) begin
               in_pkt      = 1'b0;
               bubble_pend = 1'b1;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] base0;
      RST_N = 1'b0; arb_enable = 1'b1; m_if.tready = 1'b1;
      tst_pkt_load = 2'b00; tst_pkt_val = '0;
      hs_seen = 2'b00; in_pkt = 1'b0; cur_port = 1'b0; bubble_pend = 1'b0; stall_pend = 1'b0;
      stall_data = '0;
      exp_pkt[0] = '0; exp_pkt[1] = '0; exp_beat[0] = '0; exp_beat[1] = '0;

      // Reset state
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_grant_id", grant_id, 1'b0);
      check("rst_m_tvalid", m_if.tvalid, 1'b0);
      check("rst_tready", {s1_if.tready, s0_if.tready}, 2'b00);
      check_counters("rst");
      @(posedge CLK); #2; RST_N = 1'b1;
      step();

      // 1: single 3-beat packet on port 0
      send_pkt(0, 3); exp_grant.push_back(1'b0);
      step(); check("t1_idle_cycle", busy, 1'b0);
      step(); check("t1_busy", busy, 1'b1); check("t1_grant_id", grant_id, 1'b0);
      wait_drain(); check_counters("t1");

      // 3: port 0 arrives while port 1 is mid-packet
      send_pkt(1, 4); exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
      step(); step(); step();
      send_pkt(0, 2);
      wait_drain(); check_counters("t3");

      // 4: backpressure toggling during a 4-beat packet
      send_pkt(1, 4); exp_grant.push_back(1'b1);
      for (int i = 0; i < 12; i++) begin
         m_if.tready = ~m_if.tready;
         step();
      end
      m_if.tready = 1'b1;
      wait_drain(); check_counters("t4");

      // 2: both ports continuously requesting, 2 packets each
      send_pkt(0, 2); send_pkt(0, 2); send_pkt(1, 2); send_pkt(1, 2);
`ifdef XDMA_C2H_ARB_STRICT_PRIO_EN
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1); exp_grant.push_back(1'b1);
`else
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
`endif
      wait_drain(); check_counters("t2");

      // 5: arb_enable dropped on the first beat of a 3-beat packet
      send_pkt(0, 3); exp_grant.push_back(1'b0);
      step(); step();
      check("t5_granted", busy, 1'b1);
      arb_enable = 1'b0;
      base0 = exp_pkt[0];
      send_pkt(1, 2); send_pkt(0, 2);
`ifdef XDMA_C2H_ARB_STRICT_PRIO_EN
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
`else
      exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
`endif
      for (int i = 0; i < 8; i++) step();
      check("t5_hold_busy", busy, 1'b0);
      check("t5_hold_tvalid", m_if.tvalid, 1'b0);
      check("t5_pkt_done", pkt_cnt0, base0);
      arb_enable = 1'b1;
      step();
      check("t5_regrant_busy", busy, 1'b1);
`ifdef XDMA_C2H_ARB_STRICT_PRIO_EN
      check("t5_regrant_id", grant_id, 1'b0);
`else
      check("t5_regrant_id", grant_id, 1'b1);
`endif
      wait_drain(); check_counters("t5");

      // 6: packet counter wrap from all-ones
      tst_pkt_val = 32'hFFFF_FFFF; tst_pkt_load = 2'b01;
      step();
      tst_pkt_load = 2'b00;
      check("t6_preload", pkt_cnt0, 32'hFFFF_FFFF);
      exp_pkt[0] = 32'hFFFF_FFFF;
      send_pkt(0, 1); exp_grant.push_back(1'b0);
      wait_drain();
      check("t6_wrap", pkt_cnt0, 32'd0);
      check_counters("t6");

      // 7: asynchronous reset in the middle of a port-1 packet
      send_pkt(1, 4); exp_grant.push_back(1'b1);
      step(); step(); step();
      check("t7_midpkt", {busy, grant_id}, 2'b11);
      #1 RST_N = 1'b0;
      #1;
      check("t7_busy", busy, 1'b0);
      check("t7_grant_id", grant_id, 1'b0);
      check("t7_m_tvalid", m_if.tvalid, 1'b0);
      check("t7_m_tdata", m_if.tdata, '0);
      check("t7_tready", {s1_if.tready, s0_if.tready}, 2'b00);
      exp_pkt[0] = '0; exp_pkt[1] = '0; exp_beat[0] = '0; exp_beat[1] = '0;
      check_counters("t7_rst");
      tx_q0.delete(); tx_q1.delete(); exp_q0.delete(); exp_q1.delete(); exp_grant.delete();
      step(); step();
      RST_N = 1'b1;
      step();
      send_pkt(0, 1); exp_grant.push_back(1'b0);
      wait_drain(); check_counters("t7_post");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
